ans_stream_driver: RTL
======================

// Module: ans_stream_driver
// PURPOSE
// - Host-side initiator for the 4-bit ANS core nibble interface (cmd, in/in_vld/in_rdy, out/out_vld/out_rdy).
// - Takes a byte stream from the host and splits each byte into two nibbles, low nibble first, for load, encode or decode jobs.
// - Collects the core's output nibbles and packs them back into bytes, low nibble first.
// - Holds cmd stable for the whole job; the core gates its sub-block clocks on cmd.
// PARAMETERS
// - DRAIN_IDLE  16  Drain quiet cycles (no core output) before a job is declared finished; range 1..255.
// - CNT_W       16  Width of out_count; used only with ANS_DRV_CNT_EN.
// PORTS
// - clk           in   1  Clock; all logic on rising edge.
// - rst           in   1  Synchronous, active-high reset.
// - job_cmd       in   2  01=encode, 10=decode, 11=load; sampled on start.
// - start         in   1  Begin job (1-cycle pulse); ignored when busy or when job_cmd==00.
// - byte_in       in   8  Host input byte.
// - byte_last     in   1  Qualifies byte_in as the final byte of the job.
// - byte_vld      in   1  byte_in valid.
// - byte_rdy      out  1  Driver accepts byte_in.
// - byte_out      out  8  Packed result byte; bits [3:0] are the earlier nibble.
// - byte_out_vld  out  1  byte_out valid.
// - byte_out_rdy  in   1  Host accepts byte_out.
// - core_cmd      out  2  To core cmd.
// - core_in       out  4  To core in.
// - core_in_vld   out  1  To core in_vld.
// - core_in_rdy   in   1  From core in_rdy.
// - core_out      in   4  From core out.
// - core_out_vld  in   1  From core out_vld.
// - core_out_rdy  out  1  To core out_rdy.
// - busy          out  1  High in every state except IDLE.
// - done          out  1  1-cycle pulse at job end.
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0 (core_cmd=00); nibble buffer, pack register and counters cleared. Reset aborts any job with no flush.
// - FSM states:
//   - IDLE: on start with job_cmd!=00, latch job_cmd into core_cmd and go to SEND.
//   - SEND: byte_rdy = buffer empty. Transfer on byte_vld&byte_rdy loads {byte, last}, phase=0.
//     - core_in = phase ? buf[7:4] : buf[3:0]; core_in_vld = buffer full.
//     - On core_in_vld&core_in_rdy: if phase==0, set phase=1; otherwise empty the buffer.
//     - When the high nibble of the last byte transfers: go to DONE if load, else to DRAIN.
//     - Input latency: low nibble presented the cycle after byte acceptance; next byte accepted the cycle after the high-nibble transfer.
//   - DRAIN: only output collection runs. The quiet counter:
//     - increments on cycles with !core_out_vld & !byte_out_vld;
//     - clears on any core_out transfer;
//     - holds while byte_out_vld is high.
//     - Counter reaching DRAIN_IDLE -> go to FLUSH.
//   - FLUSH: if a half nibble is pending, present byte_out={4'h0, half}. Wait for that handshake, then go to DONE; with no half pending, go to DONE immediately.
//   - DONE: done=1 for one cycle; core_cmd returns to 00 the cycle after; go to IDLE.
// - Output packing (active in SEND, DRAIN and FLUSH for encode/decode):
//   - core_out_rdy = !byte_out_vld.
//   - First nibble of a pair goes to half[3:0]; the second forms byte_out={nibble, half}, sets byte_out_vld and clears half.
//   - byte_out_vld clears on byte_out_rdy. There is no bypass: the earliest next capture is the cycle after acceptance.
// - Load mode: core_out_rdy=0; byte_out_vld is never raised.
// - Edge cases:
//   - start while busy: ignored.
//   - byte_vld while in IDLE/DRAIN/FLUSH/DONE: byte_rdy=0.
//   - Simultaneous core_in and core_out transfers in SEND: both are legal and independent.
//   - Host backpressure may stall core output indefinitely; the drain counter does not advance meanwhile.
// CONFIGURATION
// - ANS_DRV_CNT_EN defined: adds port out_count (out, CNT_W).
//   - Counts core output nibbles accepted in the current job; cleared on start and reset.
//   - Held after done until the next start; saturates at all-ones.
// - ANS_DRV_CNT_EN undefined: the port and its counter are absent; all other behaviour is identical.
// TESTING
// - Load: start cmd=11, 8 bytes 0x10..0x17 -> core_in sequence 0,1,1,1,...,7,1; core_cmd=11 throughout; done pulse; no byte_out.
// - Encode: core returns nibbles A,5,3 -> byte_out 0x5A, then 0x03 after DRAIN_IDLE quiet cycles; done after the 0x03 handshake.
// - Backpressure: byte_out_rdy=0 for 40 cycles in DRAIN -> core_out_rdy=0, no done; release -> job completes normally.
// - core_in_rdy toggling every other cycle on a 3-byte decode -> exactly 6 nibbles, in order, with no duplicates.
// - Reset asserted mid-SEND -> next cycle core_cmd=00, busy=0, byte_out_vld=0; a new start works normally.
// - ANS_DRV_CNT_EN: 5 output nibbles -> out_count=5 after done; start while busy ignored, with no change to core_cmd.

Source files
------------

// File: rtl/ans_stream_driver_if.sv
// Host byte stream, result stream and ANS core nibble handshakes for ans_stream_driver.
// Optional out_count member exists only when ANS_DRV_CNT_EN is defined.
// master = host/core environment side, slave = the driver itself.
interface ans_stream_driver_if
`ifdef ANS_DRV_CNT_EN
    #(parameter int CNT_W = 16)
`endif
    ;
    logic [1:0] job_cmd;
    logic       start;
    logic [7:0] byte_in;
    logic       byte_last;
    logic       byte_vld;
    logic       byte_rdy;
    logic [7:0] byte_out;
    logic       byte_out_vld;
    logic       byte_out_rdy;
    logic [1:0] core_cmd;
    logic [3:0] core_in;
    logic       core_in_vld;
    logic       core_in_rdy;
    logic [3:0] core_out;
    logic       core_out_vld;
    logic       core_out_rdy;
    logic       busy;
    logic       done;
`ifdef ANS_DRV_CNT_EN
    logic [CNT_W-1:0] out_count;
`endif

    modport master (
        output job_cmd, start, byte_in, byte_last, byte_vld, byte_out_rdy,
        output core_in_rdy, core_out, core_out_vld,
        input  byte_rdy, byte_out, byte_out_vld, core_cmd, core_in, core_in_vld,
        input  core_out_rdy, busy, done
`ifdef ANS_DRV_CNT_EN
        , input out_count
`endif
    );

    modport slave (
        input  job_cmd, start, byte_in, byte_last, byte_vld, byte_out_rdy,
        input  core_in_rdy, core_out, core_out_vld,
        output byte_rdy, byte_out, byte_out_vld, core_cmd, core_in, core_in_vld,
        output core_out_rdy, busy, done
`ifdef ANS_DRV_CNT_EN
        , output out_count
`endif
    );
endinterface

// File: rtl/ans_stream_driver.sv
// Purpose: host-side initiator for the 4-bit ANS core; splits bytes into nibbles and packs result nibbles into bytes.
// Latency: low nibble presented 1 cycle after byte acceptance; packed byte valid 1 cycle after its second nibble.
// Backpressure: byte_rdy waits on the nibble buffer; core_out_rdy drops while a packed byte awaits the host. Option macro: ANS_DRV_CNT_EN.
module ans_stream_driver #(
    parameter int DRAIN_IDLE = 16
`ifdef ANS_DRV_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    ans_stream_driver_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_DRAIN, S_FLUSH, S_DONE} state_t;

    localparam logic [1:0] CMD_LOAD  = 2'b11;
    localparam logic [7:0] QUIET_MAX = 8'(DRAIN_IDLE);

    state_t     state_q, state_d;
    logic [1:0] cmd_q;
    logic [7:0] buf_q;
    logic       buf_last_q, buf_full_q, phase_q;
    logic [3:0] half_q;
    logic       half_vld_q;
    logic [7:0] byte_out_q;
    logic       byte_out_vld_q;
    logic [7:0] quiet_q;

    logic start_ok, byte_rdy, byte_xfer, in_vld, nib_xfer, last_nib;
    logic pack_active, out_rdy, out_xfer, flush_load;

    // Handshake decode and next-state selection.
    always_comb begin
        state_d     = state_q;
        start_ok    = (state_q == S_IDLE) && bus.start && (bus.job_cmd != 2'b00);
        byte_rdy    = (state_q == S_SEND) && !buf_full_q;
        byte_xfer   = byte_rdy && bus.byte_vld;
        in_vld      = (state_q == S_SEND) && buf_full_q;
        nib_xfer    = in_vld && bus.core_in_rdy;
        last_nib    = nib_xfer && phase_q && buf_last_q;
        pack_active = ((state_q == S_SEND) || (state_q == S_DRAIN) || (state_q == S_FLUSH))
                      && (cmd_q != CMD_LOAD);
        out_rdy     = pack_active && !byte_out_vld_q;
        out_xfer    = out_rdy && bus.core_out_vld;
        flush_load  = (state_q == S_FLUSH) && half_vld_q && !byte_out_vld_q && !out_xfer;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_SEND;
            S_SEND:  if (last_nib) state_d = (cmd_q == CMD_LOAD) ? S_DONE : S_DRAIN;
            S_DRAIN: if (quiet_q >= QUIET_MAX) state_d = S_FLUSH;
            // Leave only once nothing is pending and no late nibble is arriving.
            S_FLUSH: if (!half_vld_q && !out_xfer && (!byte_out_vld_q || bus.byte_out_rdy))
                         state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register and job command, held from start until the cycle after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            if (start_ok)
                cmd_q <= bus.job_cmd;
            else if (state_q == S_DONE)
                cmd_q <= 2'b00;
        end
    end

    // One-byte input buffer, drained as low nibble then high nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q      <= 8'h00;
            buf_last_q <= 1'b0;
            buf_full_q <= 1'b0;
            phase_q    <= 1'b0;
        end else if (byte_xfer) begin
            buf_q      <= bus.byte_in;
            buf_last_q <= bus.byte_last;
            buf_full_q <= 1'b1;
            phase_q    <= 1'b0;
        end else if (nib_xfer) begin
            if (!phase_q)
                phase_q <= 1'b1;
            else
                buf_full_q <= 1'b0;
        end
    end

    // Output packing: first nibble parks in half, second completes the byte; flush pads an odd one.
    always_ff @(posedge clk) begin
        if (rst) begin
            half_q         <= 4'h0;
            half_vld_q     <= 1'b0;
            byte_out_q     <= 8'h00;
            byte_out_vld_q <= 1'b0;
        end else if (start_ok) begin
            half_vld_q     <= 1'b0;
            byte_out_vld_q <= 1'b0;
        end else begin
            if (byte_out_vld_q && bus.byte_out_rdy)
                byte_out_vld_q <= 1'b0;
            if (out_xfer) begin
                if (half_vld_q) begin
                    byte_out_q     <= {bus.core_out, half_q};
                    byte_out_vld_q <= 1'b1;
                    half_vld_q     <= 1'b0;
                end else begin
                    half_q     <= bus.core_out;
                    half_vld_q <= 1'b1;
                end
            end else if (flush_load) begin
                byte_out_q     <= {4'h0, half_q};
                byte_out_vld_q <= 1'b1;
                half_vld_q     <= 1'b0;
            end
        end
    end

    // Drain quiet counter: counts idle cycles, restarts on core output, freezes under host stall.
    always_ff @(posedge clk) begin
        if (rst || (state_q != S_DRAIN))
            quiet_q <= 8'h00;
        else if (out_xfer)
            quiet_q <= 8'h00;
        else if (!bus.core_out_vld && !byte_out_vld_q)
            quiet_q <= quiet_q + 8'd1;
    end

`ifdef ANS_DRV_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Per-job count of accepted core nibbles, saturating, held after done.
    always_ff @(posedge clk) begin
        if (rst || start_ok)
            cnt_q <= '0;
        else if (out_xfer && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign bus.out_count = cnt_q;
`endif

    assign bus.byte_rdy     = byte_rdy;
    assign bus.byte_out     = byte_out_q;
    assign bus.byte_out_vld = byte_out_vld_q;
    assign bus.core_cmd     = cmd_q;
    assign bus.core_in      = phase_q ? buf_q[7:4] : buf_q[3:0];
    assign bus.core_in_vld  = in_vld;
    assign bus.core_out_rdy = out_rdy;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
endmodule
